// File: rtl/volt_peak_hold.sv
// Peak-hold stage: tracks the largest |V| per refresh window and publishes it once per window.
// Optional PEAK_MINMAX_EN adds signed max/min and peak-to-peak outputs.
module volt_peak_hold #(
  parameter int               DATA_W       = 16,
  parameter int               WIN_W        = 25,
  parameter logic [WIN_W-1:0] CNT_PEAK_MAX = 25'd15000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              run_en,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_mv,
  output logic [DATA_W-1:0] peak_mv,
  output logic              peak_vld,
  output logic              win_busy,
  output logic              no_sig
`ifdef PEAK_MINMAX_EN
  ,
  output logic [DATA_W-1:0] max_mv,
  output logic [DATA_W-1:0] min_mv,
  output logic [DATA_W:0]   pp_mv
`endif
);

  // state | meaning
  // IDLE  | stopped: counter/acc held at 0, published outputs frozen
  // TRACK | window running: counter advancing, acc tracking max |V|
  typedef enum logic {ST_IDLE, ST_TRACK} state_t;

  localparam logic [WIN_W-1:0]  CNT_LAST = CNT_PEAK_MAX - 1'b1;
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              seen_q, seen_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              peak_vld_q, peak_vld_d;
  logic              no_sig_q, no_sig_d;

  logic [DATA_W-1:0] abs_mv;
  logic [DATA_W-1:0] acc_upd;
  logic              terminal;
  logic              seen_now;

  // Two's-complement magnitude; the most-negative code has no positive twin, so clamp it.
  always_comb begin
    abs_mv = sample_mv;
    if (sample_mv == NEG_MIN) begin
      abs_mv = POS_MAX;
    end else if (sample_mv[DATA_W-1]) begin
      abs_mv = ~sample_mv + 1'b1;
    end
  end

  assign acc_upd  = (sample_vld && (abs_mv > acc_q)) ? abs_mv : acc_q;
  assign terminal = (cnt_q == CNT_LAST);
  assign seen_now = seen_q | sample_vld;

`ifdef PEAK_MINMAX_EN
  localparam logic signed [DATA_W-1:0] TRK_MAX_INIT = NEG_MIN;
  localparam logic signed [DATA_W-1:0] TRK_MIN_INIT = POS_MAX;

  logic signed [DATA_W-1:0] sample_s;
  logic signed [DATA_W-1:0] max_trk_q, max_trk_d;
  logic signed [DATA_W-1:0] min_trk_q, min_trk_d;
  logic signed [DATA_W-1:0] max_upd, min_upd;
  logic [DATA_W-1:0]        max_q, max_d;
  logic [DATA_W-1:0]        min_q, min_d;
  logic [DATA_W:0]          pp_q, pp_d;

  assign sample_s = $signed(sample_mv);
  assign max_upd  = (sample_vld && (sample_s > max_trk_q)) ? sample_s : max_trk_q;
  assign min_upd  = (sample_vld && (sample_s < min_trk_q)) ? sample_s : min_trk_q;

  always_comb begin
    max_trk_d = max_trk_q;
    min_trk_d = min_trk_q;
    max_d     = max_q;
    min_d     = min_q;
    pp_d      = pp_q;
    if (state_q == ST_IDLE) begin
      max_trk_d = TRK_MAX_INIT;
      min_trk_d = TRK_MIN_INIT;
    end else if (terminal) begin
      max_trk_d = TRK_MAX_INIT;
      min_trk_d = TRK_MIN_INIT;
      if (seen_now) begin
        max_d = max_upd;
        min_d = min_upd;
        pp_d  = {max_upd[DATA_W-1], max_upd} - {min_upd[DATA_W-1], min_upd};
      end else begin
        max_d = '0;
        min_d = '0;
        pp_d  = '0;
      end
    end else if (!run_en) begin
      max_trk_d = TRK_MAX_INIT;
      min_trk_d = TRK_MIN_INIT;
    end else begin
      max_trk_d = max_upd;
      min_trk_d = min_upd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      max_trk_q <= TRK_MAX_INIT;
      min_trk_q <= TRK_MIN_INIT;
      max_q     <= '0;
      min_q     <= '0;
      pp_q      <= '0;
    end else begin
      max_trk_q <= max_trk_d;
      min_trk_q <= min_trk_d;
      max_q     <= max_d;
      min_q     <= min_d;
      pp_q      <= pp_d;
    end
  end

  assign max_mv = max_q;
  assign min_mv = min_q;
  assign pp_mv  = pp_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    seen_d     = seen_q;
    peak_d     = peak_q;
    peak_vld_d = 1'b0;
    no_sig_d   = no_sig_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        acc_d  = '0;
        seen_d = 1'b0;
        if (run_en) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        // The terminal cycle publishes even if run_en drops on it.
        if (terminal) begin
          peak_d     = acc_upd;
          peak_vld_d = 1'b1;
          no_sig_d   = ~seen_now;
          cnt_d      = '0;
          acc_d      = '0;
          seen_d     = 1'b0;
          state_d    = run_en ? ST_TRACK : ST_IDLE;
        end else if (!run_en) begin
          cnt_d   = '0;
          acc_d   = '0;
          seen_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          acc_d  = acc_upd;
          seen_d = seen_now;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      seen_q     <= 1'b0;
      peak_q     <= '0;
      peak_vld_q <= 1'b0;
      no_sig_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      seen_q     <= seen_d;
      peak_q     <= peak_d;
      peak_vld_q <= peak_vld_d;
      no_sig_q   <= no_sig_d;
    end
  end

  assign peak_mv  = peak_q;
  assign peak_vld = peak_vld_q;
  assign no_sig   = no_sig_q;
  assign win_busy = (state_q == ST_TRACK);

endmodule
